// File: rtl/alu_pkg.sv
// Shared definitions for the execute-cluster add/subtract stage:
// default widths, NZCV bit positions and a flag packing helper.
package alu_pkg;

   localparam int WIDTH_DEF = 32;
   localparam int TAG_W_DEF = 6;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   typedef logic [3:0] nzcv_t;

   function automatic nzcv_t pack_flags(input logic n, input logic z,
                                        input logic c, input logic v);
      nzcv_t f;
      f         = '0;
      f[FLAG_N] = n;
      f[FLAG_Z] = z;
      f[FLAG_C] = c;
      f[FLAG_V] = v;
      return f;
   endfunction

endpackage

// File: rtl/adder_half.sv
// N-bit ripple-carry chain of 1-bit full-adder cells with carry in/out.
module adder_half #(
   parameter int N = 16
) (
   input  logic [N-1:0] a_i,
   input  logic [N-1:0] b_i,
   input  logic         cin_i,
   output logic [N-1:0] sum_o,
   output logic         cout_o
);

   logic [N:0] c;

   assign c[0] = cin_i;

   for (genvar i = 0; i < N; i++) begin : g_fa
      assign sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
      assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
   end

   assign cout_o = c[N];

endmodule

// File: rtl/alu_add_stage.sv
// Two-stage pipelined adder/subtractor: low half plus carry in stage 1,
// high half and NZCV flags in stage 2, valid/ready on both sides, flush.
module alu_add_stage
   import alu_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int TAG_W = TAG_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             invert_b,
   input  logic             carry_in,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       flags,
   output logic [TAG_W-1:0] out_tag
);

   localparam int H = WIDTH / 2;

   logic [WIDTH-1:0] b_eff;
   logic [H-1:0]     lo_sum, hi_sum;
   logic             lo_cout, hi_cout;
   logic [WIDTH-1:0] res;
   logic             s1_advance, accept;

   logic             s1_valid_q, s1_valid_d;
   logic [H-1:0]     s1_lo_q, s1_lo_d;
   logic             s1_c_q, s1_c_d;
   logic [H-1:0]     s1_ahi_q, s1_ahi_d;
   logic [H-1:0]     s1_bhi_q, s1_bhi_d;
   logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

   logic             s2_valid_q, s2_valid_d;
   logic [WIDTH-1:0] result_q, result_d;
   nzcv_t            flags_q, flags_d;
   logic [TAG_W-1:0] tag_q, tag_d;

   assign b_eff = invert_b ? ~op_b : op_b;

   adder_half #(.N(H)) u_add_lo (
      .a_i    (op_a[H-1:0]),
      .b_i    (b_eff[H-1:0]),
      .cin_i  (carry_in),
      .sum_o  (lo_sum),
      .cout_o (lo_cout)
   );

   adder_half #(.N(H)) u_add_hi (
      .a_i    (s1_ahi_q),
      .b_i    (s1_bhi_q),
      .cin_i  (s1_c_q),
      .sum_o  (hi_sum),
      .cout_o (hi_cout)
   );

   assign res = {hi_sum, s1_lo_q};

   // in_ready must not depend on in_valid; it only sees flush, out_ready and state.
   assign s1_advance = !s2_valid_q || out_ready;
   assign in_ready   = !flush && (!s1_valid_q || s1_advance);
   assign accept     = in_valid && in_ready;

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_lo_d    = s1_lo_q;
      s1_c_d     = s1_c_q;
      s1_ahi_d   = s1_ahi_q;
      s1_bhi_d   = s1_bhi_q;
      s1_tag_d   = s1_tag_q;
      if (flush) begin
         s1_valid_d = 1'b0;
      end else if (accept) begin
         s1_valid_d = 1'b1;
         s1_lo_d    = lo_sum;
         s1_c_d     = lo_cout;
         s1_ahi_d   = op_a[WIDTH-1:H];
         s1_bhi_d   = b_eff[WIDTH-1:H];
         s1_tag_d   = in_tag;
      end else if (s1_advance) begin
         s1_valid_d = 1'b0;
      end
   end

   always_comb begin
      s2_valid_d = s2_valid_q;
      result_d   = result_q;
      flags_d    = flags_q;
      tag_d      = tag_q;
      if (flush) begin
         s2_valid_d = 1'b0;
      end else if (s1_advance) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            result_d = res;
            tag_d    = s1_tag_q;
            flags_d  = pack_flags(res[WIDTH-1], res == '0, hi_cout,
                                  (s1_ahi_q[H-1] == s1_bhi_q[H-1]) &&
                                  (res[WIDTH-1] != s1_ahi_q[H-1]));
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_lo_q    <= '0;
         s1_c_q     <= 1'b0;
         s1_ahi_q   <= '0;
         s1_bhi_q   <= '0;
         s1_tag_q   <= '0;
         s2_valid_q <= 1'b0;
         result_q   <= '0;
         flags_q    <= '0;
         tag_q      <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_lo_q    <= s1_lo_d;
         s1_c_q     <= s1_c_d;
         s1_ahi_q   <= s1_ahi_d;
         s1_bhi_q   <= s1_bhi_d;
         s1_tag_q   <= s1_tag_d;
         s2_valid_q <= s2_valid_d;
         result_q   <= result_d;
         flags_q    <= flags_d;
         tag_q      <= tag_d;
      end
   end

   assign out_valid = s2_valid_q;
   assign result    = result_q;
   assign flags     = flags_q;
   assign out_tag   = tag_q;

endmodule

// File: tb/tb_alu_add_stage.sv
// Self-checking bench for alu_add_stage: vector table, scoreboard queue,
// and hand-written stall, flush and asynchronous-reset sequences.
module tb_alu_add_stage;

   localparam int W  = 32;
   localparam int TW = 6;

   logic          clk;
   logic          rst_n;
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  op_a;
   logic [W-1:0]  op_b;
   logic          invert_b;
   logic          carry_in;
   logic [TW-1:0] in_tag;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  result;
   logic [3:0]    flags;
   logic [TW-1:0] out_tag;

   alu_add_stage #(.WIDTH(W), .TAG_W(TW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op_a      (op_a),
      .op_b      (op_b),
      .invert_b  (invert_b),
      .carry_in  (carry_in),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .flags     (flags),
      .out_tag   (out_tag)
   );

   typedef struct {
      logic [W-1:0]  r;
      logic [3:0]    f;
      logic [TW-1:0] t;
   } exp_t;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         inv;
      logic         cin;
      logic [W-1:0] r;
      logic [3:0]   f;
   } vec_t;

   exp_t sb_q[$];
   exp_t exp_cur;
   exp_t e5;
   vec_t vecs[10];

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int pops = 0;
   int last_acc_cycle = 0;
   int last_pop_cycle = 0;
   logic last_acc = 1'b0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic inv, input logic cin, input logic [TW-1:0] tag);
      exp_t e;
      logic [W:0]   s;
      logic [W-1:0] bb;
      bb  = inv ? ~b : b;
      s   = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, cin};
      e.r = s[W-1:0];
      e.f = {e.r[W-1], e.r == '0, s[W], (a[W-1] == bb[W-1]) && (e.r[W-1] != a[W-1])};
      e.t = tag;
      return e;
   endfunction

   task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic inv, input logic cin, input logic [TW-1:0] tag);
      op_a     = a;
      op_b     = b;
      invert_b = inv;
      carry_in = cin;
      in_tag   = tag;
      in_valid = 1'b1;
      exp_cur  = model(a, b, inv, cin, tag);
   endtask

   // Called right after a falling edge; evaluates both handshakes of the next rising edge.
   task automatic tick();
      exp_t e;
      logic acc;
      #1;
      acc = in_valid && in_ready;
      if (out_valid && out_ready) begin
         pops++;
         last_pop_cycle = cyc;
         if (sb_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_output: tag %h result %h with empty scoreboard", out_tag, result);
         end else begin
            e = sb_q.pop_front();
            chk("sb_result", result, e.r);
            chk("sb_flags", {28'd0, flags}, {28'd0, e.f});
            chk("sb_tag", {26'd0, out_tag}, {26'd0, e.t});
         end
      end
      if (acc) begin
         sb_q.push_back(exp_cur);
         last_acc_cycle = cyc;
      end
      last_acc = acc;
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic drain();
      int n;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      n = 0;
      while (sb_q.size() != 0 && n < 20) begin
         tick();
         n++;
      end
      chk("drain_empty", sb_q.size(), 0);
      tick();
      tick();
   endtask

   task automatic issue_until_accepted(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic inv, input logic cin,
                                       input logic [TW-1:0] tag, input logic rand_ready);
      int n;
      drive(a, b, inv, cin, tag);
      n = 0;
      do begin
         if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
         tick();
         n++;
      end while (!last_acc && n < 50);
      if (!last_acc) chk("accept_timeout", 0, 1);
   endtask

   initial begin
      int p0;
      vecs[0] = '{32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 4'b0000};
      vecs[1] = '{32'h00000005, 32'h00000005, 1'b1, 1'b1, 32'h00000000, 4'b0110};
      vecs[2] = '{32'h00000003, 32'h00000005, 1'b1, 1'b1, 32'hFFFFFFFE, 4'b1000};
      vecs[3] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 4'b1001};
      vecs[4] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 4'b0110};
      vecs[5] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 4'b0111};
      vecs[6] = '{32'h12345678, 32'h11111111, 1'b0, 1'b1, 32'h2345678A, 4'b0000};
      vecs[7] = '{32'h00000000, 32'h00000001, 1'b1, 1'b1, 32'hFFFFFFFF, 4'b1000};
      vecs[8] = '{32'h80000000, 32'h00000001, 1'b1, 1'b1, 32'h7FFFFFFF, 4'b0011};
      vecs[9] = '{32'h0000000A, 32'h00000003, 1'b1, 1'b0, 32'h00000006, 4'b0010};

      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      op_a = '0; op_b = '0; invert_b = 1'b0; carry_in = 1'b0; in_tag = '0;
      #12;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_result", result, 0);
      chk("rst_flags", {28'd0, flags}, 0);
      chk("rst_tag", {26'd0, out_tag}, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Single op: latency across the inter-stage carry.
      drive(vecs[0].a, vecs[0].b, vecs[0].inv, vecs[0].cin, 6'd0);
      exp_cur.r = vecs[0].r;
      exp_cur.f = vecs[0].f;
      tick();
      chk("first_accept", last_acc, 1);
      drain();
      chk("latency_first", last_pop_cycle - last_acc_cycle, 2);

      // Vector table, back-to-back.
      for (int i = 0; i < 10; i++) begin
         drive(vecs[i].a, vecs[i].b, vecs[i].inv, vecs[i].cin, TW'(i + 1));
         exp_cur.r = vecs[i].r;
         exp_cur.f = vecs[i].f;
         tick();
         chk("tbl_accept", last_acc, 1);
      end
      drain();

      // Tags 1..4 back-to-back: four results in four consecutive cycles.
      p0 = pops;
      for (int i = 1; i <= 4; i++) begin
         drive($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), TW'(i));
         tick();
      end
      in_valid = 1'b0;
      tick();
      tick();
      chk("b2b_count", pops - p0, 4);
      drain();

      // Backpressure: two ops buffered, then in_ready drops and outputs hold.
      p0 = pops;
      out_ready = 1'b0;
      drive(32'h00001234, 32'h00000FFF, 1'b0, 1'b0, 6'd5);
      e5 = exp_cur;
      tick();
      drive(32'h40000000, 32'h40000000, 1'b0, 1'b0, 6'd6);
      tick();
      drive(32'h00000009, 32'h00000009, 1'b1, 1'b1, 6'd7);
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("stall_in_ready", in_ready, 0);
         chk("stall_out_valid", out_valid, 1);
         chk("stall_tag", {26'd0, out_tag}, 5);
         chk("stall_result", result, e5.r);
         tick();
         chk("stall_no_accept", last_acc, 0);
      end
      out_ready = 1'b1;
      issue_until_accepted(32'h00000009, 32'h00000009, 1'b1, 1'b1, 6'd7, 1'b0);
      issue_until_accepted(32'hFFFF0000, 32'h0000FFFF, 1'b0, 1'b1, 6'd8, 1'b0);
      drain();
      chk("stall_count", pops - p0, 4);

      // Flush with two ops in flight and a third offered.
      out_ready = 1'b0;
      drive(32'h00000011, 32'h00000022, 1'b0, 1'b0, 6'd10);
      tick();
      drive(32'h00000033, 32'h00000044, 1'b0, 1'b0, 6'd11);
      tick();
      drive(32'h00000055, 32'h00000066, 1'b0, 1'b0, 6'd12);
      flush = 1'b1;
      #1;
      chk("flush_in_ready", in_ready, 0);
      tick();
      chk("flush_no_accept", last_acc, 0);
      flush = 1'b0;
      in_valid = 1'b0;
      sb_q.delete();
      #1;
      chk("flush_out_valid", out_valid, 0);
      chk("flush_in_ready_after", in_ready, 1);
      out_ready = 1'b1;
      tick();
      tick();
      drive(32'h00000100, 32'h00000001, 1'b1, 1'b1, 6'd13);
      tick();
      drain();
      chk("latency_after_flush", last_pop_cycle - last_acc_cycle, 2);

      // Asynchronous reset in the middle of a stream.
      out_ready = 1'b0;
      drive(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 6'd20);
      tick();
      drive(32'h00000002, 32'h00000003, 1'b0, 1'b0, 6'd21);
      tick();
      in_valid = 1'b0;
      #1;
      chk("pre_rst_valid", out_valid, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_out_valid", out_valid, 0);
      chk("arst_result", result, 0);
      chk("arst_flags", {28'd0, flags}, 0);
      chk("arst_tag", {26'd0, out_tag}, 0);
      sb_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      drive(32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 6'd22);
      tick();
      drain();
      chk("latency_after_rst", last_pop_cycle - last_acc_cycle, 2);

      // Random stream with random writeback backpressure.
      for (int i = 0; i < 40; i++) begin
         issue_until_accepted($urandom, $urandom, 1'($urandom_range(0, 1)),
                              1'($urandom_range(0, 1)), TW'(i), 1'b1);
      end
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
